// File: rtl/acc_dump_pkg.sv
// acc_dump_pkg: shared constants and helpers for the windowed accumulator.
package acc_dump_pkg;

    // Parameter value that selects sign extension of the incoming sample.
    localparam string SIGNED_MODE = "TRUE";

    // Ceiling log2, used to check that counter widths can hold a window index.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/acc_dump_win_counter.sv
// acc_dump_win_counter: modulo-ACC_LEN sample counter with a sync restart.
// It flags the first sample of a window (counter at 0 or sync) and the
// sample that completes a window.
module acc_dump_win_counter
    import acc_dump_pkg::*;
#(
    parameter int ACC_LEN   = 16,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync,
    input  logic                 din_valid,
    output logic [CNT_WIDTH-1:0] win_cnt,
    output logic                 first,
    output logic                 last
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACC_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);
    localparam bit                   SINGLE   = (ACC_LEN == 1);

    // Refuse to build with a counter too narrow for the window.
    if ((CNT_WIDTH < 1) || (CNT_WIDTH < clog2(ACC_LEN)) || (ACC_LEN < 1)) begin : g_bad_params
        $error("acc_dump_win_counter: CNT_WIDTH too small for ACC_LEN");
    end

    // A sync sample always starts a fresh window, so it can only complete one when the window is a single sample.
    always_comb begin
        first = sync || (win_cnt == '0);
        last  = 1'b0;
        if (din_valid) begin
            last = sync ? SINGLE : (win_cnt == LAST_CNT);
        end
    end

    // Count accepted samples, wrapping at the window end and restarting on sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
        end else if (sync || din_valid) begin
            if (last || !din_valid) begin
                win_cnt <= '0;
            end else if (sync) begin
                win_cnt <= ONE_CNT;
            end else begin
                win_cnt <= win_cnt + ONE_CNT;
            end
        end
    end

endmodule

// File: rtl/acc_dump.sv
// acc_dump: integrate-and-dump accumulator. Sums ACC_LEN valid samples
// modulo 2^OUT_WIDTH and presents each completed window sum with a
// one-cycle dout_valid strobe; sync discards the partial window.
module acc_dump
    import acc_dump_pkg::*;
#(
    parameter int    IN_WIDTH     = 5,
    parameter string IN_IS_SIGNED = "TRUE",
    parameter int    ACC_LEN      = 16,
    parameter int    OUT_WIDTH    = 9,
    parameter int    CNT_WIDTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync,
    input  logic                 din_valid,
    input  logic [IN_WIDTH-1:0]  din,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic [CNT_WIDTH-1:0] win_cnt
);

    localparam bit SIGN_EXTEND = (IN_IS_SIGNED == SIGNED_MODE);

    logic [OUT_WIDTH-1:0] din_ext;
    logic [OUT_WIDTH-1:0] add_base;
    logic [OUT_WIDTH-1:0] sum;
    logic [OUT_WIDTH-1:0] acc;
    logic                 first;
    logic                 last;

    // The accumulator must be at least as wide as the sample.
    if (OUT_WIDTH < IN_WIDTH) begin : g_bad_width
        $error("acc_dump: OUT_WIDTH must be >= IN_WIDTH");
    end

    acc_dump_win_counter #(
        .ACC_LEN   (ACC_LEN),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_win_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync      (sync),
        .din_valid (din_valid),
        .win_cnt   (win_cnt),
        .first     (first),
        .last      (last)
    );

    // Widen the sample, then add it to the running sum, or to zero on the first sample, so no clear cycle is needed.
    always_comb begin
        din_ext = OUT_WIDTH'(din);
        if (SIGN_EXTEND) begin
            din_ext = OUT_WIDTH'($signed(din));
        end
        add_base = first ? '0 : acc;
        sum      = add_base + din_ext;
    end

    // Hold the running sum and publish it with a single-cycle strobe when a window completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= last;
            if (din_valid) begin
                acc <= sum;
            end
            if (last) begin
                dout <= sum;
            end
        end
    end

endmodule
